// File: rtl/decn_pkg.sv
// rtl/decn_pkg.sv - shared types and decode helpers for the decn_scan decoder
//
// Purpose : mode/state enums and the one-hot / thermometer encoders used by
//           decn_scan.
// Contents: mode_t, state_t, MAX_N, MAX_W, onehot(), therm().

package decn_pkg;

  // Encoding of the Mode input; MODE_RSV falls back to decode.
  typedef enum logic [1:0] {
    MODE_DEC   = 2'b00,
    MODE_THERM = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSV   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_DEC   = 2'b00,
    S_THERM = 2'b01,
    S_SCAN  = 2'b10
  } state_t;

  // The helpers work at the widest supported select width.
  // Callers zero-extend their index to MAX_N bits and truncate
  // the result to their own 2**N output width.
  localparam int MAX_N = 8;
  localparam int MAX_W = 1 << MAX_N;

  // One bit set at position idx.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] idx);
    logic [MAX_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Bits 0..idx set, everything above clear (idx = 0 still lights bit 0).
  function automatic logic [MAX_W-1:0] therm(input logic [MAX_N-1:0] idx);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = ($unsigned(i) <= 32'(idx));
    end
    return r;
  endfunction

endpackage

// File: rtl/decn_dwell_cnt.sv
// rtl/decn_dwell_cnt.sv - scan dwell counter with terminal-compare advance strobe
//
// Purpose : counts cycles spent on the current scan position and flags when
//           the position should advance.
// Ports   :
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   clear  in   force the count to zero (scan entry / outside scan)
//   run    in   count this cycle (scanning and enabled)
//   dwell  in   cycles per position minus one
//   adv    out  combinational advance strobe for the current cycle

module decn_dwell_cnt
  import decn_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               adv
);

  logic [DWELL_W-1:0] cnt;

  // A >= compare rather than == means a dwell value lowered below the
  // running count advances on the very next cycle, and the count can
  // never run past dwell or wrap around.
  assign adv = run && (cnt >= dwell);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (adv) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decn_scan.sv
// rtl/decn_scan.sv - registered N-to-2**N decoder with thermometer and scan modes
//
// Purpose : drives digit/row select lines; decode, thermometer or an
//           autonomous one-hot scan with programmable dwell.
// Ports   :
//   Clock  in   rising-edge clock
//   Reset  in   synchronous active-high reset
//   En     in   output enable / scan advance enable
//   Mode   in   00 decode, 01 thermometer, 10 scan, 11 decode
//   W      in   select index; start index on scan entry
//   Dwell  in   scan cycles per position minus one
//   Y      out  registered decoded output, Y[i] <-> index i
//   Idx    out  registered index currently shown
//   Step   out  one-cycle pulse when a scan advance happens
//   Wrap   out  one-cycle pulse on the OUTW-1 -> 0 scan advance

module decn_scan
  import decn_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               En,
  input  logic [1:0]         Mode,
  input  logic [N-1:0]       W,
  input  logic [DWELL_W-1:0] Dwell,
  output logic [2**N-1:0]    Y,
  output logic [N-1:0]       Idx,
  output logic               Step,
  output logic               Wrap
);

  localparam int OUTW = 2**N;

  state_t state, state_next;

  logic            entry;
  logic            cnt_run;
  logic            cnt_clear;
  logic            adv;

  logic [OUTW-1:0] y_d;
  logic [N-1:0]    idx_d;
  logic            step_d;
  logic            wrap_d;

  // State register: holds the previous cycle's decoded state so that
  // scan entry can be recognised.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_DEC;
    end else begin
      state <= state_next;
    end
  end

  // Next state follows Mode every cycle; the reserved code decodes.
  always_comb begin
    state_next = S_DEC;
    case (mode_t'(Mode))
      MODE_THERM: state_next = S_THERM;
      MODE_SCAN:  state_next = S_SCAN;
      default:    state_next = S_DEC;
    endcase
  end

  assign entry     = (state_next == S_SCAN) && (state != S_SCAN);
  assign cnt_run   = (state_next == S_SCAN) && !entry && En;
  assign cnt_clear = (state_next != S_SCAN) || entry;

  decn_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (Clock),
    .reset (Reset),
    .clear (cnt_clear),
    .run   (cnt_run),
    .dwell (Dwell),
    .adv   (adv)
  );

  // Output decode: computes what the output registers load this edge.
  always_comb begin
    y_d    = '0;
    idx_d  = Idx;
    step_d = 1'b0;
    wrap_d = 1'b0;
    case (state_next)
      S_THERM: begin
        if (En) begin
          y_d   = OUTW'(therm(MAX_N'(W)));
          idx_d = W;
        end
      end
      S_SCAN: begin
        if (entry) begin
          // Entry loads the start index and restarts the dwell count;
          // no advance is possible on this edge.
          idx_d = W;
          if (En) begin
            y_d = OUTW'(onehot(MAX_N'(W)));
          end
        end else if (En) begin
          if (adv) begin
            idx_d  = Idx + 1'b1;
            step_d = 1'b1;
            wrap_d = (Idx == '1);
          end
          y_d = OUTW'(onehot(MAX_N'(idx_d)));
        end
      end
      default: begin
        if (En) begin
          y_d   = OUTW'(onehot(MAX_N'(W)));
          idx_d = W;
        end
      end
    endcase
  end

  // Output registers: every output is a flop, so Y is glitch-free and
  // there is no combinational path from inputs to outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Y    <= '0;
      Idx  <= '0;
      Step <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      Y    <= y_d;
      Idx  <= idx_d;
      Step <= step_d;
      Wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_decn_scan.sv
// tb/tb_decn_scan.sv - directed self-checking bench for decn_scan

module tb_decn_scan;

  logic       Clock;
  logic       Reset;
  logic       En;
  logic [1:0] Mode;
  logic [2:0] W;
  logic [7:0] Dwell;
  logic [7:0] Y;
  logic [2:0] Idx;
  logic       Step;
  logic       Wrap;

  int checks = 0;
  int errors = 0;

  decn_scan #(
    .N       (3),
    .DWELL_W (8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .En    (En),
    .Mode  (Mode),
    .W     (W),
    .Dwell (Dwell),
    .Y     (Y),
    .Idx   (Idx),
    .Step  (Step),
    .Wrap  (Wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] exp_idx4  [7] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0};
  logic       exp_step4 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       exp_wrap4 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] exp_y4    [7] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01};
  logic [7:0] exp_y2    [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    Reset = 1'b1;
    En    = 1'b0;
    Mode  = 2'b00;
    W     = 3'd0;
    Dwell = 8'd0;

    // Reset state
    tick();
    tick();
    chk("rst_y", 32'(Y), 32'h00);
    chk("rst_idx", 32'(Idx), 32'd0);
    chk("rst_step", 32'(Step), 32'd0);
    chk("rst_wrap", 32'(Wrap), 32'd0);

    // 1. Reset mid-scan
    Reset = 1'b0;
    Mode  = 2'b10;
    W     = 3'd3;
    Dwell = 8'd0;
    En    = 1'b1;
    tick();
    tick();
    tick();
    chk("t1_pre_idx", 32'(Idx), 32'd5);
    chk("t1_pre_step", 32'(Step), 32'd1);
    Reset = 1'b1;
    tick();
    chk("t1_rst_y", 32'(Y), 32'h00);
    chk("t1_rst_idx", 32'(Idx), 32'd0);
    chk("t1_rst_step", 32'(Step), 32'd0);
    chk("t1_rst_wrap", 32'(Wrap), 32'd0);
    tick();
    chk("t1_rst2_y", 32'(Y), 32'h00);
    chk("t1_rst2_step", 32'(Step), 32'd0);
    Reset = 1'b0;

    // 2. Decode sweep
    Mode = 2'b00;
    En   = 1'b1;
    for (int w = 0; w < 8; w++) begin
      W = 3'(w);
      tick();
      chk("t2_dec_y", 32'(Y), 32'(exp_y2[w]));
      chk("t2_dec_idx", 32'(Idx), 32'(w));
      chk("t2_dec_step", 32'(Step), 32'd0);
    end
    En = 1'b0;
    W  = 3'd2;
    tick();
    chk("t2_off_y", 32'(Y), 32'h00);
    chk("t2_off_idx", 32'(Idx), 32'd7);

    // 3. Thermometer and reserved mode
    Mode = 2'b01;
    En   = 1'b1;
    W    = 3'd0;
    tick();
    chk("t3_th0_y", 32'(Y), 32'h01);
    chk("t3_th0_idx", 32'(Idx), 32'd0);
    W = 3'd3;
    tick();
    chk("t3_th3_y", 32'(Y), 32'h0F);
    W = 3'd7;
    tick();
    chk("t3_th7_y", 32'(Y), 32'hFF);
    chk("t3_th7_idx", 32'(Idx), 32'd7);
    Mode = 2'b11;
    W    = 3'd5;
    tick();
    chk("t3_rsv_y", 32'(Y), 32'h20);
    chk("t3_rsv_idx", 32'(Idx), 32'd5);

    // 4. Scan, Dwell = 2, start at 6
    Mode  = 2'b10;
    W     = 3'd6;
    Dwell = 8'd2;
    En    = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      W = 3'd1;  // ignored after entry
      chk("t4_idx", 32'(Idx), 32'(exp_idx4[k]));
      chk("t4_step", 32'(Step), 32'(exp_step4[k]));
      chk("t4_wrap", 32'(Wrap), 32'(exp_wrap4[k]));
      chk("t4_y", 32'(Y), 32'(exp_y4[k]));
    end

    // 5. Scan, Dwell = 0, En low for 4 cycles
    Mode = 2'b00;
    tick();
    Mode  = 2'b10;
    W     = 3'd2;
    Dwell = 8'd0;
    En    = 1'b1;
    tick();
    chk("t5_entry_idx", 32'(Idx), 32'd2);
    chk("t5_entry_step", 32'(Step), 32'd0);
    tick();
    chk("t5_adv1_idx", 32'(Idx), 32'd3);
    chk("t5_adv1_step", 32'(Step), 32'd1);
    tick();
    chk("t5_adv2_idx", 32'(Idx), 32'd4);
    chk("t5_adv2_y", 32'(Y), 32'h10);
    En = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_off_y", 32'(Y), 32'h00);
      chk("t5_off_idx", 32'(Idx), 32'd4);
      chk("t5_off_step", 32'(Step), 32'd0);
    end
    En = 1'b1;
    tick();
    chk("t5_resume_idx", 32'(Idx), 32'd5);
    chk("t5_resume_y", 32'(Y), 32'h20);
    chk("t5_resume_step", 32'(Step), 32'd1);

    // 6. Dwell lowered mid-position
    Mode = 2'b00;
    tick();
    Mode  = 2'b10;
    W     = 3'd0;
    Dwell = 8'd200;
    tick();
    chk("t6_entry_y", 32'(Y), 32'h01);
    for (int k = 0; k < 150; k++) begin
      tick();
    end
    chk("t6_hold_idx", 32'(Idx), 32'd0);
    chk("t6_hold_step", 32'(Step), 32'd0);
    Dwell = 8'd10;
    tick();
    chk("t6_fast_idx", 32'(Idx), 32'd1);
    chk("t6_fast_step", 32'(Step), 32'd1);
    chk("t6_fast_y", 32'(Y), 32'h02);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_dwell_step", 32'(Step), 32'd0);
      chk("t6_dwell_idx", 32'(Idx), 32'd1);
    end
    tick();
    chk("t6_next_idx", 32'(Idx), 32'd2);
    chk("t6_next_step", 32'(Step), 32'd1);

    // Leaving scan
    Mode = 2'b00;
    W    = 3'd4;
    tick();
    chk("exit_y", 32'(Y), 32'h10);
    chk("exit_idx", 32'(Idx), 32'd4);
    chk("exit_step", 32'(Step), 32'd0);
    chk("exit_wrap", 32'(Wrap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
